// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: fetches a 32-bit instruction a byte per cycle, then sequences LB/SB/R-type/BEQ/J.
// Optional ADDI support is compiled in with `define MIPS_CONTROLLER_ADDI_EN.
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14,
    UNUSED  = 4'd15
  } stateT;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  stateT state_q, state_d;

  logic       pcenRaw;
  logic [3:0] irwriteRaw;
  logic       memreadRaw;
  logic       memwriteRaw;
  logic       regwriteRaw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
  end

  // Moore decode of the state register; only BEQEX looks at zero.
  always_comb begin
    state_d     = FETCH1;
    pcenRaw     = 1'b0;
    iord        = 1'b0;
    irwriteRaw  = 4'b0000;
    memreadRaw  = 1'b0;
    memwriteRaw = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwriteRaw = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    alucont     = 3'b000;
    pcsource    = 2'b00;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memreadRaw = 1'b1;
        irwriteRaw = 4'b0001 << state_q[1:0];
        alusrcb    = 2'b01;
        alucont    = 3'b010;
        pcenRaw    = 1'b1;
        state_d    = (state_q == FETCH4) ? DECODE : stateT'(state_q + 4'd1);
      end
      DECODE: begin
        alusrcb = 2'b11;
        alucont = 3'b010;
        case (op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
`ifdef MIPS_CONTROLLER_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default:      state_d = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = 3'b010;
        state_d = (op == OP_LB) ? LBRD : SBWR;
      end
      LBRD: begin
        memreadRaw = 1'b1;
        iord       = 1'b1;
        state_d    = LBWR;
      end
      LBWR: begin
        regwriteRaw = 1'b1;
        memtoreg    = 1'b1;
      end
      SBWR: begin
        memwriteRaw = 1'b1;
        iord        = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucont = 3'b010;
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b010;
        endcase
        state_d = RTYPEWR;
      end
      RTYPEWR: begin
        regwriteRaw = 1'b1;
        regdst      = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        alucont  = 3'b110;
        pcsource = 2'b01;
        pcenRaw  = zero;
      end
      JEX: begin
        pcsource = 2'b10;
        pcenRaw  = 1'b1;
      end
`ifdef MIPS_CONTROLLER_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = 3'b010;
        state_d = ADDIWR;
      end
      ADDIWR: begin
        regwriteRaw = 1'b1;
      end
`endif
      default: state_d = FETCH1;
    endcase
  end

  // Write strobes are held off while reset is asserted so no mid-instruction side effect escapes.
  assign pcen     = pcenRaw & ~reset;
  assign irwrite  = irwriteRaw & {4{~reset}};
  assign memread  = memreadRaw & ~reset;
  assign memwrite = memwriteRaw & ~reset;
  assign regwrite = regwriteRaw & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h3f;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       pcen, iord, memread, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [3:0] irwrite;
  logic [1:0] alusrcb;
  logic [2:0] alucont;
  logic [1:0] pcsource;
  logic [3:0] state;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [18:0] outs;
  } expT;

  expT expQ[$];
  int  checksTotal = 0;
  int  checksPassed = 0;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memread(memread), .memwrite(memwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucont(alucont), .pcsource(pcsource), .state(state)
  );

  always #5 clk = ~clk;

  function automatic expT mk(input string n, input logic [3:0] st, input logic pc, input logic io,
                             input logic [3:0] irw, input logic mr, input logic mw, input logic rd,
                             input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
                             input logic [2:0] ac, input logic [1:0] ps);
    expT e;
    e.name = n;
    e.st   = st;
    e.outs = {pc, io, irw, mr, mw, rd, m2r, rw, asa, asb, ac, ps};
    return e;
  endfunction

  // Each call spans one clock cycle; the expectation describes outputs during that cycle.
  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input expT e);
    @(posedge clk);
    #1;
    reset = r;
    op    = o;
    funct = f;
    zero  = z;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    logic [18:0] act;
    act = {pcen, iord, irwrite, memread, memwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucont, pcsource};
    checksTotal++;
    if (state === e.st && act === e.outs) checksPassed++;
    else $display("[TB] FAIL %s: actual state=%0d outs=%b, required state=%0d outs=%b",
                  e.name, state, act, e.st, e.outs);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic doFetch();
    applyStimulus(0, 6'b000100, 6'h00, 1'b0, mk("fetch1", 4'd0, 1, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00));
    applyStimulus(0, 6'b100000, 6'h2a, 1'b0, mk("fetch2", 4'd1, 1, 0, 4'b0010, 1, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00));
    applyStimulus(0, 6'b000010, 6'h22, 1'b1, mk("fetch3", 4'd2, 1, 0, 4'b0100, 1, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00));
    applyStimulus(0, 6'b101000, 6'h00, 1'b0, mk("fetch4", 4'd3, 1, 0, 4'b1000, 1, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00));
  endtask

  task automatic doDecode(input logic [5:0] o, input string n);
    applyStimulus(0, o, 6'h00, 1'b0, mk(n, 4'd4, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00));
  endtask

  task automatic doRtype(input logic [5:0] f, input logic [2:0] ac, input string n);
    doFetch();
    doDecode(6'b000000, "rtype_decode");
    applyStimulus(0, 6'b000000, f, 1'b0, mk(n, 4'd9, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b00, ac, 2'b00));
    applyStimulus(0, 6'b100000, 6'b100010, 1'b0, mk("rtypewr", 4'd10, 0, 0, 4'b0000, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00));
  endtask

  initial begin
    // Reset cycle: FETCH1 state with write strobes gated off.
    applyStimulus(1, 6'h3f, 6'h00, 1'b0, mk("reset_gate", 4'd0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00));

    // LB: op changes during LBRD/LBWR must be ignored.
    doFetch();
    doDecode(6'b100000, "lb_decode");
    applyStimulus(0, 6'b100000, 6'h00, 1'b0, mk("lb_memadr", 4'd5, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00));
    applyStimulus(0, 6'b101000, 6'h00, 1'b0, mk("lbrd", 4'd6, 0, 1, 4'b0000, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00));
    applyStimulus(0, 6'b000000, 6'h00, 1'b0, mk("lbwr", 4'd7, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00));

    // SB
    doFetch();
    doDecode(6'b101000, "sb_decode");
    applyStimulus(0, 6'b101000, 6'h00, 1'b0, mk("sb_memadr", 4'd5, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00));
    applyStimulus(0, 6'b100000, 6'h00, 1'b0, mk("sbwr", 4'd8, 0, 1, 4'b0000, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00));

    // R-type ALU control decode
    doRtype(6'b101010, 3'b111, "rtype_slt");
    doRtype(6'b100010, 3'b110, "rtype_sub");
    doRtype(6'b100101, 3'b001, "rtype_or");
    doRtype(6'b100100, 3'b000, "rtype_and");
    doRtype(6'b000111, 3'b010, "rtype_unknown");

    // BEQ taken and not taken
    doFetch();
    doDecode(6'b000100, "beq_decode");
    applyStimulus(0, 6'b000000, 6'h00, 1'b1, mk("beq_zero1", 4'd11, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01));
    doFetch();
    doDecode(6'b000100, "beq_decode");
    applyStimulus(0, 6'b000000, 6'h00, 1'b0, mk("beq_zero0", 4'd11, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01));

    // J
    doFetch();
    doDecode(6'b000010, "j_decode");
    applyStimulus(0, 6'h3f, 6'h00, 1'b0, mk("jex", 4'd12, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10));

    // Illegal op returns straight to FETCH1
    doFetch();
    doDecode(6'b111111, "illegal_decode");

    // ADDI
    doFetch();
    doDecode(6'b001000, "addi_decode");
`ifdef MIPS_CONTROLLER_ADDI_EN
    applyStimulus(0, 6'h3f, 6'h00, 1'b0, mk("addiex", 4'd13, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00));
    applyStimulus(0, 6'h3f, 6'h00, 1'b0, mk("addiwr", 4'd14, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00));
`endif

    // Reset asserted during SBWR: memwrite gated, next cycle is FETCH1.
    doFetch();
    doDecode(6'b101000, "sb_decode");
    applyStimulus(0, 6'b101000, 6'h00, 1'b0, mk("sb_memadr", 4'd5, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00));
    applyStimulus(1, 6'b101000, 6'h00, 1'b0, mk("sbwr_reset", 4'd8, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00));

    // Reset asserted during RTYPEEX aborts the write-back.
    doFetch();
    doDecode(6'b000000, "rtype_decode");
    applyStimulus(1, 6'b000000, 6'b101010, 1'b0, mk("rtypeex_reset", 4'd9, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00));
    doFetch();

    @(posedge clk);
    repeat (3) @(negedge clk);
    checksTotal++;
    if (expQ.size() == 0) checksPassed++;
    else $display("[TB] FAIL drain: actual %0d entries left, required 0", expQ.size());
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
